// File: rtl/audio_pkg.sv
// audio_pkg: mode codes, FSM state encodings and the saturating adder shared by the echo datapath
package audio_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_DELAY  = 2'd1;
  localparam logic [1:0] MODE_ECHO   = 2'd2;
  localparam logic [1:0] MODE_MUTE   = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_MIX  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;

  // Adds two sign-extended operands and clamps the sum to the signed range of a w-bit sample.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// audio_delay_ram: simple dual-port sample-pair buffer, one write port and one registered read port
module audio_delay_ram #(
  parameter int W  = 64,
  parameter int AW = 15
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];

  // Unreset storage with a one-cycle synchronous read so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/audio_delay_echo.sv
// audio_delay_echo: stereo delay/echo stage between the audio input FIFO and output FIFO
module audio_delay_echo
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = 32,
  parameter int ADDR_W      = 15,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                read_audio_in,
  input  logic                audio_out_allowed,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                write_audio_out,
  output logic                busy
);

  localparam int PW = 2 * SAMPLE_W;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]                 state_q, state_d;
  logic [1:0]                 mode_q;
  logic [ADDR_W-1:0]          dlen_q, dlen_in, wr_ptr_q, rd_addr;
  logic [ADDR_W:0]            fill_q;
  logic signed [SAMPLE_W-1:0] in_l_q, in_r_q, dly_l_q, dly_r_q, out_l_q, out_r_q;
  logic signed [SAMPLE_W-1:0] echo_l, echo_r, mix_l, mix_r;
  logic [PW-1:0]              rd_data, wr_data;
  logic                       wr_en;

  // A zero delay would read the slot about to be written, so it is promoted to one.
  assign dlen_in = delay_len == '0 ? ADDR_W'(1) : delay_len;
  assign rd_addr = wr_ptr_q - dlen_in;

  assign read_audio_in           = state_q == S_RD;
  assign wr_en                   = state_q == S_WR && audio_out_allowed;
  assign write_audio_out         = wr_en;
  assign busy                    = state_q != S_IDLE;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;

  // Echo recirculates the mixed output; every other mode records the dry input.
  assign wr_data = mode_q == MODE_ECHO ? {out_l_q, out_r_q} : {in_l_q, in_r_q};

  // Fixed pop -> read -> mix -> push sequence; only the push may stall.
  always_comb begin
    state_d = state_q == S_IDLE ? (audio_in_available ? S_RD : S_IDLE) :
              state_q == S_RD   ? S_MEM :
              state_q == S_MEM  ? S_MIX :
              state_q == S_MIX  ? S_WR  :
              audio_out_allowed ? S_IDLE : S_WR;
  end

  // Output mixer: the delayed term is attenuated and saturated only in echo mode.
  always_comb begin
    echo_l = SAMPLE_W'(sat_add(64'(in_l_q), 64'(dly_l_q >>> ATTEN_SHIFT), SAMPLE_W));
    echo_r = SAMPLE_W'(sat_add(64'(in_r_q), 64'(dly_r_q >>> ATTEN_SHIFT), SAMPLE_W));
    mix_l  = mode_q == MODE_BYPASS ? in_l_q : mode_q == MODE_DELAY ? dly_l_q : mode_q == MODE_ECHO ? echo_l : '0;
    mix_r  = mode_q == MODE_BYPASS ? in_r_q : mode_q == MODE_DELAY ? dly_r_q : mode_q == MODE_ECHO ? echo_r : '0;
  end

  // Pipeline registers, write pointer and fill level; fill masks slots not yet written since reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_BYPASS;
      dlen_q   <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      dly_l_q  <= '0;
      dly_r_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RD) begin
        in_l_q <= left_channel_audio_in;
        in_r_q <= right_channel_audio_in;
        mode_q <= mode;
        dlen_q <= dlen_in;
      end
      if (state_q == S_MEM) begin
        dly_l_q <= fill_q < {1'b0, dlen_q} ? '0 : rd_data[PW-1:SAMPLE_W];
        dly_r_q <= fill_q < {1'b0, dlen_q} ? '0 : rd_data[SAMPLE_W-1:0];
      end
      if (state_q == S_MIX) begin
        out_l_q <= mix_l;
        out_r_q <= mix_r;
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q   <= fill_q == DEPTH ? fill_q : fill_q + 1'b1;
      end
    end
  end

  audio_delay_ram #(.W(PW), .AW(ADDR_W)) u_ram (
    .clk_i  (CLOCK_50),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

endmodule
